serial_sub_ctrl: RTL and testbench

Bit-serial N-bit subtractor controller built around one 1-bit full subtractor cell (FS_SUB: A - B - C -> Diff, Borrow). It latches two operands on a start request, then feeds the cell one bit per clock, LSB first, chaining the borrow through a register. After WIDTH cycles it presents the difference, borrow-out and signed overflow, with a done pulse. It trades a WIDTH-bit ripple subtractor for one cell plus shift registers, for area-limited datapaths.

---
 rtl/serial_sub_ctrl_pkg.sv | 21 ++
 rtl/FS_SUB.sv | 13 +
 rtl/serial_sub_ctrl.sv | 135 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller: FSM encoding
// and the counter-width helper.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/FS_SUB.sv
// One-bit full subtractor cell: A - B - C -> Diff, Borrow. Purely combinational.
module FS_SUB (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Diff,
  output logic Borrow
);

  assign Diff   = A ^ B ^ C;
  assign Borrow = (~A & B) | (~A & C) | (B & C);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one FS_SUB cell fed LSB first, borrow
// chained through a register, result/borrow/overflow presented with a done pulse.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             fs_diff;
  logic             fs_borrow;

  FS_SUB u_fs_sub (
    .A      (a_sr_q[0]),
    .B      (b_sr_q[0]),
    .C      (brw_q),
    .Diff   (fs_diff),
    .Borrow (fs_borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          brw_d   = bin;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Difference bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        r_sr_d = {fs_diff, r_sr_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = fs_borrow;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        diff_d  = r_sr_q;
        bout_d  = brw_q;
        ovf_d   = (a_msb_q != b_msb_q) && (r_sr_q[WIDTH-1] != a_msb_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout, ovf;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_diff;
  logic         last_bout, last_ovf;
  logic         done_prev = 1'b0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // done must never stay high for two consecutive cycles.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(done && done_prev)) else begin
        errors++;
        $error("FAIL done_double: observed=1 expected=0");
      end
    end
    done_prev <= rst ? 1'b0 : done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic logic [W:0] gold_ud(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic gbin);
    int unsigned r;
    r = 32'(ga) - 32'(gb) - 32'(gbin);
    return (W+1)'(r);
  endfunction

  function automatic logic gold_ovf(input logic [W-1:0] ga, input logic [W-1:0] gb, input logic gbin);
    int sa, sb, r;
    sa = int'($signed(ga));
    sb = int'($signed(gb));
    r  = sa - sb - int'(gbin);
    return (r < -(2 ** (W-1))) || (r > (2 ** (W-1)) - 1);
  endfunction

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin, input string tag);
    int n, busy_cycles;
    logic [W:0] exp_ud;
    logic exp_ovf;
    exp_ud  = gold_ud(ia, ib, ibin);
    exp_ovf = gold_ovf(ia, ib, ibin);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    n = 0; busy_cycles = 0;
    while (!done && n < 50) begin
      if (busy) busy_cycles++;
      if (n == 4) check({tag, "_hold"}, {55'd0, last_bout, diff}, {55'd0, last_bout, last_diff});
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(W + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W + 1));
    check({tag, "_bout_diff"}, 64'({bout, diff}), 64'(exp_ud));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    last_diff = exp_ud[W-1:0];
    last_bout = exp_ud[W];
    last_ovf  = exp_ovf;
    step();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    step(); step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_outs", 64'({ovf, bout, diff}), 64'd0);
    rst = 1'b0;
    step(); step();
    check("idle_busy", 64'(busy), 64'd0);

    do_op(8'h5A, 8'h3C, 1'b0, "basic");
    do_op(8'h00, 8'h01, 1'b0, "underflow");
    do_op(8'h10, 8'h0F, 1'b1, "bin_zero");
    do_op(8'h80, 8'h01, 1'b0, "ovf_neg");
    do_op(8'h7F, 8'hFF, 1'b0, "ovf_pos");
    do_op(8'hA5, 8'hA5, 1'b0, "equal");
    do_op(8'hA5, 8'hA5, 1'b1, "equal_bin");
    do_op(8'h00, 8'hFF, 1'b1, "zero_minus_ones");

    // start held high: one done every W+2 cycles, each with the same result.
    begin
      int n;
      start = 1'b1; a = 8'h33; b = 8'h11; bin = 1'b0;
      step();
      for (int k = 1; k < 40; k++) begin
        step();
        check("b2b_done", 64'(done), 64'((k % (W + 2)) == (W + 1)));
        if (done) check("b2b_diff", 64'({bout, diff}), 64'h022);
      end
      start = 1'b0;
      n = 0;
      while (!done && n < 50) begin step(); n++; end
      check("b2b_tail_done", 64'(done), 64'd1);
      step();
      last_diff = 8'h22; last_bout = 1'b0; last_ovf = 1'b0;
    end

    // Reset during RUN clears outputs immediately and suppresses done.
    begin
      int seen;
      start = 1'b1; a = 8'hF0; b = 8'h0F; bin = 1'b0;
      step();
      start = 1'b0;
      repeat (4) step();
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_done", 64'(done), 64'd0);
      check("midrst_outs", 64'({ovf, bout, diff}), 64'd0);
      step(); step();
      rst = 1'b0;
      seen = 0;
      repeat (15) begin
        step();
        if (done) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
      do_op(8'h09, 8'h03, 1'b0, "after_rst");
    end

    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
